// File: rtl/qam_packet_mapper_if.sv
// Bundle between the serial baseband source and the QAM packet mapper.
// Stream/control signals flow master -> slave, mapped symbols flow back.
interface qam_packet_mapper_if #(
    parameter int ADDR_W = 9,
    parameter int OUT_W  = 5
) ();
    logic              enable;
    logic [1:0]        mode;
    logic              data_in;
    logic              data_valid;
    logic              sym_valid;
    logic [OUT_W-1:0]  sym_i;
    logic [OUT_W-1:0]  sym_q;
    logic [ADDR_W-1:0] sym_addr;
    logic              busy;
    logic              pkt_done;

    modport master (
        output enable, mode, data_in, data_valid,
        input  sym_valid, sym_i, sym_q, sym_addr, busy, pkt_done
    );

    modport slave (
        input  enable, mode, data_in, data_valid,
        output sym_valid, sym_i, sym_q, sym_addr, busy, pkt_done
    );
endinterface

// File: rtl/qam_packet_mapper.sv
// M-QAM packet mapper: hunts a serial stream for a header, then slices
// the payload into 2/4/6/8-bit symbols and maps them to signed I/Q levels.
module qam_packet_mapper #(
    parameter int                 SYMBOLS_PER_PACKET = 512,
    parameter int                 HDR_LEN            = 12,
    parameter logic [HDR_LEN-1:0] HEADER             = 12'b101100_111000,
    parameter int                 ADDR_W             = 9,
    parameter int                 OUT_W              = 5
) (
    input logic               data_clk,
    input logic               rst,
    qam_packet_mapper_if.slave bus
);
    typedef enum logic {
        S_HUNT    = 1'b0,
        S_PAYLOAD = 1'b1
    } state_t;

    localparam int FILL_W = $clog2(HDR_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(HDR_LEN);
    localparam logic [FILL_W-1:0] FILL_ARM  = FILL_W'(HDR_LEN - 1);
    localparam logic [ADDR_W-1:0] LAST_SYM  = ADDR_W'(SYMBOLS_PER_PACKET - 1);

    state_t             r_state;
    state_t             w_next_state;

    logic [HDR_LEN-1:0] r_hdr;
    logic [FILL_W-1:0]  r_fill;
    logic [1:0]         r_k;
    logic [2:0]         r_bit;
    logic [6:0]         r_sym;
    logic [ADDR_W-1:0]  r_scnt;
    logic               r_sym_valid;
    logic               r_pkt_done;
    logic [OUT_W-1:0]   r_sym_i;
    logic [OUT_W-1:0]   r_sym_q;
    logic [ADDR_W-1:0]  r_sym_addr;

    logic               w_accept;
    logic               w_match;
    logic               w_sym_done;
    logic               w_last;
    logic [HDR_LEN-1:0] w_hdr_shift;
    logic [7:0]         w_sym_full;
    logic [3:0]         w_ci;
    logic [3:0]         w_cq;
    logic [OUT_W-1:0]   w_off;
    logic [OUT_W-1:0]   w_lvl_i;
    logic [OUT_W-1:0]   w_lvl_q;

    // A bit is taken only when both enabled and qualified valid.
    assign w_accept    = bus.enable & bus.data_valid;
    assign w_hdr_shift = {r_hdr[HDR_LEN-2:0], bus.data_in};
    assign w_sym_full  = {r_sym, bus.data_in};

    // Fill counter gates the match so short streams can never hit.
    assign w_match = (r_state == S_HUNT) && w_accept &&
                     (r_fill >= FILL_ARM) && (w_hdr_shift == HEADER);

    // k-1 equals {mode, 1} for k = 2, 4, 6, 8.
    assign w_sym_done = (r_state == S_PAYLOAD) && w_accept &&
                        (r_bit == {r_k, 1'b1});
    assign w_last     = w_sym_done && (r_scnt == LAST_SYM);

    // Split the completed symbol into I/Q codes and pick the level offset.
    always_comb begin
        w_ci  = 4'd0;
        w_cq  = 4'd0;
        w_off = OUT_W'(1);
        unique case (r_k)
            2'b00: begin
                w_ci  = {3'b000, w_sym_full[1]};
                w_cq  = {3'b000, w_sym_full[0]};
                w_off = OUT_W'(1);
            end
            2'b01: begin
                w_ci  = {2'b00, w_sym_full[3:2]};
                w_cq  = {2'b00, w_sym_full[1:0]};
                w_off = OUT_W'(3);
            end
            2'b10: begin
                w_ci  = {1'b0, w_sym_full[5:3]};
                w_cq  = {1'b0, w_sym_full[2:0]};
                w_off = OUT_W'(7);
            end
            2'b11: begin
                w_ci  = w_sym_full[7:4];
                w_cq  = w_sym_full[3:0];
                w_off = OUT_W'(15);
            end
            default: begin
                w_ci  = 4'd0;
                w_cq  = 4'd0;
                w_off = OUT_W'(1);
            end
        endcase
    end

    // Level = 2c - (2^(k/2)-1); modular OUT_W arithmetic yields two's complement.
    assign w_lvl_i = OUT_W'({w_ci, 1'b0}) - w_off;
    assign w_lvl_q = OUT_W'({w_cq, 1'b0}) - w_off;

    // State register.
    always_ff @(posedge data_clk) begin
        if (rst) begin
            r_state <= S_HUNT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; disable forces the hunt state.
    always_comb begin
        w_next_state = r_state;
        if (!bus.enable) begin
            w_next_state = S_HUNT;
        end else begin
            unique case (r_state)
                S_HUNT:    if (w_match) w_next_state = S_PAYLOAD;
                S_PAYLOAD: if (w_last)  w_next_state = S_HUNT;
                default:   w_next_state = S_HUNT;
            endcase
        end
    end

    // Header hunt, symbol assembly and registered symbol outputs.
    always_ff @(posedge data_clk) begin
        if (rst) begin
            r_hdr       <= '0;
            r_fill      <= '0;
            r_k         <= 2'b00;
            r_bit       <= 3'd0;
            r_sym       <= 7'd0;
            r_scnt      <= '0;
            r_sym_valid <= 1'b0;
            r_pkt_done  <= 1'b0;
            r_sym_i     <= '0;
            r_sym_q     <= '0;
            r_sym_addr  <= '0;
        end else begin
            r_sym_valid <= 1'b0;
            r_pkt_done  <= 1'b0;
            if (!bus.enable) begin
                r_hdr  <= '0;
                r_fill <= '0;
                r_bit  <= 3'd0;
                r_sym  <= 7'd0;
                r_scnt <= '0;
            end else if (r_state == S_HUNT) begin
                if (w_match) begin
                    r_k    <= bus.mode;
                    r_bit  <= 3'd0;
                    r_sym  <= 7'd0;
                    r_scnt <= '0;
                    r_hdr  <= '0;
                    r_fill <= '0;
                end else if (w_accept) begin
                    r_hdr <= w_hdr_shift;
                    if (r_fill != FILL_FULL) begin
                        r_fill <= r_fill + 1'b1;
                    end
                end
            end else if (w_accept) begin
                if (w_sym_done) begin
                    r_bit       <= 3'd0;
                    r_sym       <= 7'd0;
                    r_sym_valid <= 1'b1;
                    r_sym_i     <= w_lvl_i;
                    r_sym_q     <= w_lvl_q;
                    r_sym_addr  <= r_scnt;
                    r_scnt      <= r_scnt + 1'b1;
                    if (w_last) begin
                        r_pkt_done <= 1'b1;
                        r_scnt     <= '0;
                        r_hdr      <= '0;
                        r_fill     <= '0;
                    end
                end else begin
                    r_bit <= r_bit + 3'd1;
                    r_sym <= w_sym_full[6:0];
                end
            end
        end
    end

    // Output drive; busy follows the payload state directly.
    always_comb begin
        bus.busy      = (r_state == S_PAYLOAD);
        bus.sym_valid = r_sym_valid;
        bus.pkt_done  = r_pkt_done;
        bus.sym_i     = r_sym_i;
        bus.sym_q     = r_sym_q;
        bus.sym_addr  = r_sym_addr;
    end
endmodule

// File: tb/tb_qam_packet_mapper.sv
// Directed bench for qam_packet_mapper: header hunt, all four modes,
// gapped input, abort, reset and back-to-back packets.
module tb_qam_packet_mapper;
    localparam logic [11:0] HDR = 12'b101100111000;

    typedef struct {
        logic [4:0] i;
        logic [4:0] q;
        logic [8:0] a;
        logic       d;
        logic       b;
        int         c;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_done = 0;
    logic busy_seen = 1'b0;
    ent_t log_q[$];

    always #5 clk = ~clk;

    qam_packet_mapper_if #(.ADDR_W(9), .OUT_W(5)) bus ();

    qam_packet_mapper dut (
        .data_clk (clk),
        .rst      (rst),
        .bus      (bus)
    );

    // Cycle counter for strobe timing.
    always @(posedge clk) cyc++;

    // Record every strobe and pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.sym_valid) begin
            log_q.push_back('{bus.sym_i, bus.sym_q, bus.sym_addr,
                              bus.pkt_done, bus.busy, cyc});
        end
        if (bus.pkt_done) n_done++;
        if (bus.busy) busy_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic b, input logic v);
        bus.data_in    = b;
        bus.data_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] val, input int n);
        for (int j = n - 1; j >= 0; j--) step(val[j], 1'b1);
    endtask

    task automatic abort();
        bus.enable = 1'b0;
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        bus.enable = 1'b1;
        step(1'b0, 1'b0);
    endtask

    initial begin
        int bad;
        int ldone;
        logic [5:0] gsym;
        rst            = 1'b1;
        bus.enable     = 1'b1;
        bus.mode       = 2'b10;
        bus.data_in    = 1'b0;
        bus.data_valid = 1'b0;
        @(posedge clk);
        #1;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("rst_valid_done_busy",
              {bus.sym_valid, bus.pkt_done, bus.busy}, 0);
        check("rst_iq", {bus.sym_i, bus.sym_q}, 0);
        check("rst_addr", bus.sym_addr, 0);
        rst = 1'b0;
        step(1'b0, 1'b0);

        // 64-QAM, two packets back to back.
        log_q.delete();
        n_done = 0;
        for (int p = 0; p < 2; p++) begin
            send(HDR, 12);
            if (p == 0) check("b2b_busy_after_hdr", bus.busy, 1);
            for (int s = 0; s < 512; s++) begin
                send(s[0] ? 6'b111000 : 6'b000111, 6);
            end
        end
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("b2b_count", log_q.size(), 1024);
        check("b2b_done_count", n_done, 2);
        check("q64_first_i", log_q[0].i, 5'b11001);
        check("q64_first_q", log_q[0].q, 5'b00111);
        check("q64_first_addr", log_q[0].a, 0);
        check("q64_second_i", log_q[1].i, 5'b00111);
        check("q64_second_q", log_q[1].q, 5'b11001);
        check("q64_second_addr", log_q[1].a, 1);
        check("q64_spacing", log_q[1].c - log_q[0].c, 6);
        check("q64_last_addr", log_q[511].a, 511);
        check("q64_last_done", log_q[511].d, 1);
        check("q64_last_busy", log_q[511].b, 0);
        check("q64_prev_busy_done", {log_q[510].b, log_q[510].d}, 2'b10);
        check("b2b_second_addr0", log_q[512].a, 0);
        check("b2b_second_done", log_q[1023].d, 1);
        bad = 0;
        for (int n = 0; n < 1024; n++) begin
            if (log_q[n].a != 9'(n % 512)) bad++;
        end
        check("b2b_addr_seq", bad, 0);
        check("b2b_busy_end", bus.busy, 0);

        // QPSK, 16-QAM and 256-QAM.
        log_q.delete();
        n_done = 0;
        bus.mode = 2'b00;
        send(HDR, 12);
        send(2'b10, 2);
        send(2'b10, 2);
        step(1'b0, 1'b0);
        abort();
        check("qpsk_count", log_q.size(), 2);
        check("qpsk_i", log_q[0].i, 5'b00001);
        check("qpsk_q", log_q[0].q, 5'b11111);
        check("qpsk_spacing", log_q[1].c - log_q[0].c, 2);

        log_q.delete();
        bus.mode = 2'b01;
        send(HDR, 12);
        send(4'b0110, 4);
        send(4'b0110, 4);
        step(1'b0, 1'b0);
        abort();
        check("q16_count", log_q.size(), 2);
        check("q16_i", log_q[0].i, 5'b11111);
        check("q16_q", log_q[0].q, 5'b00001);
        check("q16_spacing", log_q[1].c - log_q[0].c, 4);

        log_q.delete();
        bus.mode = 2'b11;
        send(HDR, 12);
        send(8'hF0, 8);
        send(8'hF0, 8);
        step(1'b0, 1'b0);
        abort();
        check("q256_count", log_q.size(), 2);
        check("q256_i", log_q[0].i, 5'b01111);
        check("q256_q", log_q[0].q, 5'b10001);
        check("q256_spacing", log_q[1].c - log_q[0].c, 8);
        check("modes_no_done", n_done, 0);

        // Wrong header: alternating stream never matches.
        log_q.delete();
        busy_seen = 1'b0;
        bus.mode = 2'b10;
        for (int n = 0; n < 600; n++) step(~n[0], 1'b1);
        step(1'b0, 1'b0);
        check("wrong_hdr_no_strobe", log_q.size(), 0);
        check("wrong_hdr_no_busy", busy_seen, 0);

        // Random prefix: match only on the final header bit.
        send($urandom_range(0, 31), 5);
        send(HDR >> 1, 11);
        check("prefix_no_early_match", bus.busy, 0);
        step(HDR[0], 1'b1);
        check("prefix_match", bus.busy, 1);
        abort();

        // Gapped 64-QAM symbol 011010 -> I=-1, Q=-3.
        log_q.delete();
        gsym = 6'b011010;
        ldone = 0;
        send(HDR, 12);
        for (int j = 5; j >= 0; j--) begin
            step(gsym[j], 1'b1);
            ldone = cyc;
            if (j > 0) step(1'b1, 1'b0);
        end
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("gap_count", log_q.size(), 1);
        check("gap_timing", log_q[0].c, ldone);
        check("gap_iq", {log_q[0].i, log_q[0].q}, {5'b11111, 5'b11101});
        abort();

        // Abort after symbol 100, with a mode change mid-packet.
        log_q.delete();
        n_done = 0;
        bus.mode = 2'b10;
        send(HDR, 12);
        bus.mode = 2'b00;
        for (int s = 0; s < 101; s++) send(6'b000111, 6);
        send(3'b000, 3);
        bus.enable = 1'b0;
        for (int n = 0; n < 20; n++) step(1'b1, 1'b1);
        check("abort_count", log_q.size(), 101);
        check("abort_last_addr", log_q[100].a, 100);
        check("abort_mode_spacing", log_q[1].c - log_q[0].c, 6);
        bad = 0;
        foreach (log_q[n]) begin
            if (log_q[n].i != 5'b11001 || log_q[n].q != 5'b00111) bad++;
        end
        check("abort_mode_values", bad, 0);
        check("abort_no_done", n_done, 0);
        check("abort_busy", bus.busy, 0);

        // Re-enable with a fresh header; addressing restarts.
        bus.enable = 1'b1;
        step(1'b0, 1'b0);
        log_q.delete();
        bus.mode = 2'b01;
        send(HDR, 12);
        send(4'b1111, 4);
        step(1'b0, 1'b0);
        check("reen_count", log_q.size(), 1);
        check("reen_addr", log_q[0].a, 0);
        check("reen_iq", {log_q[0].i, log_q[0].q}, {5'b00011, 5'b00011});
        abort();

        // Reset in the middle of a payload.
        log_q.delete();
        bus.mode = 2'b10;
        send(HDR, 12);
        for (int s = 0; s < 3; s++) send(6'b000111, 6);
        send(2'b00, 2);
        check("pre_rst_hold", {bus.sym_i, bus.sym_addr}, {5'b11001, 9'd2});
        rst = 1'b1;
        step(1'b0, 1'b1);
        check("mid_rst_outputs",
              {bus.sym_valid, bus.sym_i, bus.sym_q, bus.sym_addr,
               bus.busy, bus.pkt_done}, 0);
        rst = 1'b0;
        send(4'b0111, 4);
        step(1'b0, 1'b0);
        check("post_rst_no_strobe", log_q.size(), 3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/qam_packet_mapper.md
# qam_packet_mapper

Parametrised M-QAM packet mapper: hunts a serial baseband bit stream for a fixed header, then slices the following payload into symbols of 2, 4, 6 or 8 bits and maps each to signed I/Q amplitude levels with a buffer write address. It generalises the fixed 64-QAM mapping path to run-time selectable QPSK/16/64/256-QAM, a configurable header and packet length, and gapped input through a valid qualifier. It sits between the serial baseband input and the symbol storage register bank. The SPI block owns the `enable` and `mode` register bits.

## Interface
- `SYMBOLS_PER_PACKET`, default 512: payload symbols per packet; must be at least 2.
- `HDR_LEN`, default 12: header length in bits.
- `HEADER`, default 12'b101100_111000: header pattern, MSB received first.
- `ADDR_W`, default 9: symbol address width; must satisfy 2^ADDR_W >= SYMBOLS_PER_PACKET.
- `OUT_W`, fixed at 5: width of signed I/Q outputs, enough for ±15.

Ports:
- `data_clk` input 1: the single clock. All logic is rising-edge.
- `rst` input 1: reset, synchronous, active-high.
- `enable` input 1: mapping enable. Low aborts and holds the block in hunt.
- `mode` input 2: 00 QPSK (k=2), 01 16-QAM (k=4), 10 64-QAM (k=6), 11 256-QAM (k=8).
- `data_in` input 1: serial baseband bit, MSB-first per symbol.
- `data_valid` input 1: `data_in` is accepted only on cycles where `data_valid` is high.
- `sym_valid` output 1: one-cycle strobe marking a mapped symbol.
- `sym_i` output OUT_W: two's-complement I level.
- `sym_q` output OUT_W: two's-complement Q level.
- `sym_addr` output ADDR_W: index of the symbol within the packet, 0..SYMBOLS_PER_PACKET-1.
- `busy` output 1: high while in PAYLOAD.
- `pkt_done` output 1: one-cycle strobe, asserted with the last symbol's `sym_valid`.

## Operation
- Reset values: state=HUNT, header shift register and fill counter cleared, and `sym_valid`, `sym_i`, `sym_q`, `sym_addr`, `busy`, `pkt_done` all 0.
- **HUNT**
  - Each accepted bit shifts into the HDR_LEN-bit register, LSB in.
  - The fill counter saturates at HDR_LEN.
  - A match is taken when the fill counter has reached HDR_LEN (counting the current bit) and {register[HDR_LEN-2:0], data_in} equals HEADER.
  - A bit stream shorter than HDR_LEN since entry into HUNT never matches, including for an all-zero HEADER.
  - On a match: next state=PAYLOAD; latch `mode` into k_lat; clear the bit and symbol counters.
  - A mode change after the match has no effect until the next packet.
- **PAYLOAD**
  - Accepted bits shift into the symbol register.
  - On the cycle the k_lat-th bit is accepted, the symbol completes and the bit counter clears.
  - Upper k/2 bits = I code cI; lower k/2 bits = Q code cQ.
  - Level = 2·c − (2^(k/2) − 1), sign-extended to OUT_W. For 64-QAM this gives code 0→−7 and code 7→+7.
  - `sym_addr` = symbol counter value; the counter then increments.
  - When symbol SYMBOLS_PER_PACKET-1 completes, assert `pkt_done` and return to HUNT with the header register and fill counter cleared.
  - Bits after the last payload bit belong to HUNT, so back-to-back packets are supported.
  - The symbol counter never wraps inside a packet.
- `enable` low on any edge:
  - The next state is HUNT, all counters and shift registers are cleared, and no further `sym_valid` is issued.
  - A partial packet is discarded with no `pkt_done`.
  - Bits are not accepted while `enable` is low.
- `rst` mid-packet behaves like `enable` low, and additionally returns all outputs to their reset values.
- `sym_i`, `sym_q` and `sym_addr` hold their last value between strobes.

## Timing
- Header match on edge N: `busy`=1 from cycle N+1. The first payload bit can be accepted in cycle N+1.
- Last bit of a symbol accepted on edge N: `sym_valid`, `sym_i`, `sym_q` and `sym_addr` are registered and visible in cycle N+1 for exactly one cycle.
- With continuous `data_valid`, `sym_valid` repeats every k_lat cycles.
- `data_valid` gaps stretch the symbol period and never duplicate or drop a strobe.
- Final symbol: `sym_valid` and `pkt_done` are high in the same cycle, and `busy` drops in that same cycle.
- Throughput: one bit per clock. There is no backpressure; the downstream buffer must accept every strobe.

## Test plan
- **64-QAM, continuous:**
  - Stimulus: mode=10, header 101100111000, then symbols 000111, 111000, …, 512 symbols in total.
  - Required: first strobe I=5'b11001 (−7), Q=5'b00111 (+7), addr 0; second strobe I=+7, Q=−7, addr 1; `pkt_done` with addr 511; `busy` low afterwards.
- **Modes:**
  - QPSK symbol 10 → I=+1, Q=−1.
  - 16-QAM symbol 0110 → I=−1, Q=+1.
  - 256-QAM symbol 8'hF0 → I=+15 (01111), Q=−15 (10001).
  - Strobe spacing equals 2, 4 or 8 cycles respectively under continuous valid.
- **Wrong or short header:**
  - Stream 101010101010 repeated for 600 bits → no `sym_valid`, `busy` stays 0.
  - Header preceded by 5 random bits → matches on the correct bit only.
- **Gapped input:**
  - `data_valid` toggles 1-0-1-0 during a 64-QAM symbol → a single strobe, 1 cycle after the 6th accepted bit, with a correct value.
- **Abort:**
  - `enable` dropped after symbol 100 → no further strobes and no `pkt_done`.
  - Re-enable with a new header → addr restarts at 0.
  - Mode changed mid-packet → ignored.
- **Reset and back-to-back packets:**
  - `rst` mid-payload → all outputs 0 on the next cycle.
  - Two packets sent back-to-back → 1024 strobes and 2 `pkt_done` pulses.
